// File: rtl/alarm_clock_pkg.sv
// Shared constants for the alarm clock set/load logic.
// Hour and minute loaders are the same design with different parameters.
package alarm_clock_pkg;

    localparam int HOUR_MAX = 23;
    localparam int HOUR_W   = 5;
    localparam int MIN_MAX  = 59;
    localparam int MIN_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDIT = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

endpackage

// File: rtl/btn_repeat.sv
// Edge detector with hold-to-repeat for one button.
// Emits a one-cycle step on the press and then on each auto-repeat tick.
module btn_repeat #(
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic clk,
    input  logic clr,
    input  logic level,
    input  logic clear,
    output logic step
);

    localparam int CW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
    localparam logic [CW-1:0] DLY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE = CW'(REPEAT_RATE);

    logic          prev;
    logic          rpt;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          hit;

    assign rise = level & ~prev;
    // cnt holds cycles since the last step; it is 0 on the press cycle, so hit cannot alias rise
    assign hit  = (cnt == (rpt ? RATE : DLY));
    assign step = level & ~clear & (rise | hit);

    always_ff @(posedge clk) begin
        if (!clr) begin
            prev <= 1'b0;
            rpt  <= 1'b0;
            cnt  <= '0;
        end else begin
            prev <= level;
            if (!level || clear) begin
                rpt <= 1'b0;
                cnt <= '0;
            end else if (rise) begin
                rpt <= 1'b0;
                cnt <= CW'(1);
            end else if (hit) begin
                rpt <= 1'b1;
                cnt <= CW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hour_set_loader.sv
// Stages a new hour value from Set/Inc/Dec/Cancel buttons and commits it
// to the hour counter with a one-cycle LD/LD_EN strobe.
module hour_set_loader
    import alarm_clock_pkg::*;
#(
    parameter int WIDTH        = HOUR_W,
    parameter int MAX_VAL      = HOUR_MAX,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    parameter int TIMEOUT      = 1000
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Set,
    input  logic             Inc,
    input  logic             Dec,
    input  logic             Cancel,
    input  logic [WIDTH-1:0] CUR,
    output logic [WIDTH-1:0] LOAD_VAL,
    output logic             LD,
    output logic             LD_EN,
    output logic             EDITING
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam int               TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] stage, stage_nxt;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic             set_prev, cancel_prev;
    logic             set_rise, cancel_rise;
    logic             inc_step, dec_step;
    logic             rpt_clear;

    assign set_rise    = Set & ~set_prev;
    assign cancel_rise = Cancel & ~cancel_prev;
    // Repeat counters only run in EDIT, and Inc+Dec together cancel each other out
    assign rpt_clear   = (state != ST_EDIT) | (Inc & Dec);

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_inc (
        .clk(Clk), .clr(Clr), .level(Inc), .clear(rpt_clear), .step(inc_step)
    );

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dec (
        .clk(Clk), .clr(Clr), .level(Dec), .clear(rpt_clear), .step(dec_step)
    );

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        tcnt_nxt  = '0;
        case (state)
            ST_IDLE: begin
                if (set_rise) begin
                    state_nxt = ST_EDIT;
                    stage_nxt = (CUR > MAXV) ? '0 : CUR;
                end
            end
            ST_EDIT: begin
                if (cancel_rise) begin
                    state_nxt = ST_IDLE;
                end else if (set_rise) begin
                    state_nxt = ST_LOAD;
                end else if (Inc || Dec) begin
                    if (inc_step)
                        stage_nxt = (stage == MAXV) ? '0 : stage + WIDTH'(1);
                    else if (dec_step)
                        stage_nxt = (stage == '0) ? MAXV : stage - WIDTH'(1);
                end else if (tcnt == TMO_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            ST_LOAD: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state       <= ST_IDLE;
            stage       <= '0;
            tcnt        <= '0;
            set_prev    <= 1'b0;
            cancel_prev <= 1'b0;
            LOAD_VAL    <= '0;
            LD          <= 1'b0;
            LD_EN       <= 1'b0;
            EDITING     <= 1'b0;
        end else begin
            state       <= state_nxt;
            stage       <= stage_nxt;
            tcnt        <= tcnt_nxt;
            set_prev    <= Set;
            cancel_prev <= Cancel;
            // Outputs follow the current state by one cycle, so reset during LOAD suppresses LD
            LOAD_VAL    <= stage;
            LD          <= (state == ST_LOAD);
            LD_EN       <= (state == ST_LOAD);
            EDITING     <= (state != ST_IDLE);
        end
    end

endmodule

// File: doc/hour_set_loader.md
Name: hour_set_loader

Overview:
- Writer side of the hour counter's parallel-load interface.
- Lets the user stage a new hour value (0-23) with Set/Inc/Dec/Cancel buttons.
- Commits the staged value with a single-cycle load strobe (LD plus Enable plus a 5-bit value) into the 0-23 hour counter.
- Sits between the debounced button block and the hour counter; also drives the staged value to the display mux while editing.

Parameters:
- WIDTH, 5, bit width of the hour value and load bus.
- MAX_VAL, 23, highest legal value; wrap point in both directions.
- REPEAT_DELAY, 50, cycles Inc/Dec must be held before auto-repeat starts (>=2).
- REPEAT_RATE, 10, cycles between auto-repeat steps once repeating (>=1).
- TIMEOUT, 1000, idle cycles in EDIT before abandoning the edit without loading.

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Clr  input  1  reset, synchronous, active-low.
- Set  input  1  debounced level; rising edge enters edit / commits.
- Inc  input  1  debounced level; increment staged value.
- Dec  input  1  debounced level; decrement staged value.
- Cancel  input  1  debounced level; rising edge aborts edit.
- CUR  input  WIDTH  current counter value, copied into the stage on edit entry.
- LOAD_VAL  output  WIDTH  staged value / load data, registered.
- LD  output  1  load strobe, one cycle.
- LD_EN  output  1  enable for the counter, high only together with LD.
- EDITING  output  1  high in EDIT and LOAD states.

Behaviour:
- Reset: Clr low at a Clk rising edge puts the block in IDLE.
  - Reset values: LOAD_VAL=0, LD=0, LD_EN=0, EDITING=0, stage=0, all edge/repeat/timeout counters=0, previous-level registers=0.
  - Reset has priority over everything, including mid-EDIT and mid-LOAD. A LOAD cycle pre-empted by reset emits no LD.
- Edge detection: each button has a previous-level register.
  - rise = level & ~prev.
  - The action happens at the same edge where the level is first sampled high.
  - Holding a button gives exactly one rise.
- IDLE:
  - Set rise -> EDIT; stage <= CUR, or 0 if CUR > MAX_VAL.
  - EDITING=1 from the next cycle.
  - Inc, Dec and Cancel are ignored.
- EDIT, with priority Cancel > Set > Inc/Dec:
  - Cancel rise -> IDLE; no LD; stage retained.
  - Set rise -> LOAD.
  - Inc step: stage = (stage==MAX_VAL) ? 0 : stage+1.
  - Dec step: stage = (stage==0) ? MAX_VAL : stage-1.
  - Inc and Dec both high: no step; both repeat counters held at 0.
  - Auto-repeat, per held button:
    - Rise gives step 1.
    - After REPEAT_DELAY further held cycles, one step.
    - Then one step every REPEAT_RATE cycles.
    - Release resets that button's repeat counter.
  - Timeout counter:
    - Cleared on any rise, or while Inc/Dec is held.
    - Otherwise increments.
    - Reaching TIMEOUT-1 -> IDLE, no LD.
- LOAD, exactly one cycle:
  - LD=1, LD_EN=1, LOAD_VAL=stage.
  - Next state is IDLE unconditionally; all button rises in this cycle are ignored.
  - Latency: Set rise sampled at edge n gives LD high in cycle n+1..n+2, registered outputs.
- LOAD_VAL: tracks stage in every state (registered), so the display sees edits one cycle after the step.
- LD and LD_EN: never high outside LOAD; never high for more than one consecutive cycle.
- Stage: never exceeds MAX_VAL; arithmetic is WIDTH bits, with no carry out.

Decomposition:
- Shared package (alarm_clock_pkg):
  - HOUR_MAX=23 and HOUR_W=5.
  - State encoding constants ST_IDLE, ST_EDIT, ST_LOAD (2-bit).
  - The same package later carries MIN_MAX=59 and MIN_W=6 for a minute_set_loader built by parameter override.
- Sub-module btn_repeat:
  - Edge detect plus REPEAT_DELAY/REPEAT_RATE counter.
  - Outputs a one-cycle step pulse.
  - Instantiated twice, for Inc and Dec.
  - The top handles the Inc&Dec conflict by gating.

Test Plan:
- Reset and idle: Clr low 3 cycles with all buttons high, then release with buttons low -> all outputs 0, state IDLE, no LD ever.
- Commit flow: CUR=14, Set pulse, Inc pulse x3, Set pulse -> EDITING=1, LOAD_VAL steps 14,15,16,17; exactly one LD=LD_EN=1 cycle with LOAD_VAL=17; then EDITING=0.
- Wrap both ways:
  - CUR=22, enter edit, Inc x3 -> 23,0,1.
  - Dec x3 -> 0,23,22.
  - Commit -> LD with 22.
- Auto-repeat (REPEAT_DELAY=4, REPEAT_RATE=2): CUR=0, enter edit, hold Inc 12 cycles -> steps at cycles 0,4,6,8,10; LOAD_VAL=5; Inc+Dec held together -> no change.
- Abort paths:
  - Cancel pulse in EDIT -> IDLE, no LD.
  - No buttons for TIMEOUT cycles -> IDLE, no LD.
  - Set+Cancel rising together -> cancel wins.
- Reset mid-operation: Clr low in the cycle Set commits (LOAD) -> no LD pulse; outputs 0. CUR=27 on edit entry -> stage=0.
